// File: rtl/n64_bus_scheduler_pkg.sv
// Shared definitions for the N64 bus scheduler: device IDs, cartridge
// address map and scheduler FSM states.
package sc64;

  // SoC-side device slots behind the PI bus.
  typedef enum logic [2:0] {
    ID_SDRAM      = 3'd0,
    ID_BOOTLOADER = 3'd1,
    ID_FLASHRAM   = 3'd2,
    ID_DDREGS     = 3'd3,
    ID_CFG        = 3'd4
  } e_n64_id;

  // Cartridge address map, inclusive bounds.
  localparam logic [31:0] N64_CFG_BASE   = 32'h1FFC_0000;
  localparam logic [31:0] N64_CFG_END    = 32'h1FFC_FFFF;
  localparam logic [31:0] N64_BOOT_BASE  = 32'h1000_0000;
  localparam logic [31:0] N64_BOOT_END   = 32'h1FFB_FFFF;
  localparam logic [31:0] N64_FLASH_BASE = 32'h0800_0000;
  localparam logic [31:0] N64_FLASH_END  = 32'h0FFF_FFFF;
  localparam logic [31:0] N64_DD_BASE    = 32'h0500_0000;
  localparam logic [31:0] N64_DD_END     = 32'h05FF_FFFF;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WAIT   = 2'd2
  } e_sched_state;

endpackage

// File: rtl/n64_bus_decoder.sv
// Combinational cartridge address decoder. Maps a PI byte address and the
// live map enables onto a device slot. Standalone so the PI front end can
// reuse it for early bus turnaround.
module n64_bus_decoder
  import sc64::*;
(
  input  logic [31:0] address,
  input  logic        cfg_bootloader_en,
  input  logic        cfg_flashram_en,
  input  logic        cfg_dd_en,
  output logic        hit,
  output e_n64_id     id
);

  // First matching range wins; CFG is carved out of the top of the boot window.
  always_comb begin
    hit = 1'b0;
    id  = ID_SDRAM;
    if (address >= N64_CFG_BASE && address <= N64_CFG_END) begin
      hit = 1'b1;
      id  = ID_CFG;
    end else if (address >= N64_BOOT_BASE && address <= N64_BOOT_END) begin
      hit = 1'b1;
      id  = cfg_bootloader_en ? ID_BOOTLOADER : ID_SDRAM;
    end else if (address >= N64_FLASH_BASE && address <= N64_FLASH_END) begin
      hit = 1'b1;
      id  = cfg_flashram_en ? ID_FLASHRAM : ID_SDRAM;
    end else if (address >= N64_DD_BASE && address <= N64_DD_END) begin
      hit = cfg_dd_en;
      id  = ID_DDREGS;
    end
  end

endmodule

// File: rtl/n64_bus_scheduler.sv
// N64 PI bus scheduler: latches one PI request, routes it to exactly one
// SoC device slot, waits for that slot's ack (bounded by a timeout) and
// returns the completion upstream. One transaction in flight at a time.
//
// Handshake: req is a one-cycle pulse accepted only while req_busy is low;
// any req seen while req_busy is high is dropped and flags err_overrun.
// req_busy also covers the req_ack cycle, so the next req is accepted in
// the cycle right after req_ack. dev_request is a one-cycle one-hot pulse;
// the device answers with a one-cycle dev_ack on its own slot, with
// dev_rdata valid in that same cycle.
module n64_bus_scheduler
  import sc64::*;
#(
  parameter int NUM_DEVICES    = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_bootloader_en,
  input  logic                      cfg_flashram_en,
  input  logic                      cfg_dd_en,
  input  logic                      req,
  input  logic                      req_write,
  input  logic [31:0]               req_address,
  input  logic [15:0]               req_wdata,
  output logic                      req_busy,
  output logic                      req_ack,
  output logic [15:0]               req_rdata,
  output logic                      req_hit,
  output logic                      req_timeout,
  output logic [NUM_DEVICES-1:0]    dev_request,
  output logic                      dev_write,
  output logic [31:0]               dev_address,
  output logic [15:0]               dev_wdata,
  input  logic [NUM_DEVICES-1:0]    dev_ack,
  input  logic [16*NUM_DEVICES-1:0] dev_rdata,
  output logic                      err_timeout,
  output logic                      err_overrun,
  input  logic                      err_clear,
  output logic [1:0]                dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  e_sched_state            state_q, state_d;
  e_n64_id                 id_q, id_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    hit_q, hit_d;
  logic                    tmo_q, tmo_d;
  logic [NUM_DEVICES-1:0]  dreq_q, dreq_d;
  logic                    dwrite_q, dwrite_d;
  logic [31:0]             daddr_q, daddr_d;
  logic [15:0]             dwdata_q, dwdata_d;
  logic                    err_tmo_q, err_tmo_d;
  logic                    err_ovr_q, err_ovr_d;

  logic                    dec_hit;
  e_n64_id                 dec_id;
  logic                    sel_ack;
  logic [15:0]             sel_rdata;
  logic                    tmo_set;

  n64_bus_decoder u_decoder (
    .address           (daddr_q),
    .cfg_bootloader_en (cfg_bootloader_en),
    .cfg_flashram_en   (cfg_flashram_en),
    .cfg_dd_en         (cfg_dd_en),
    .hit               (dec_hit),
    .id                (dec_id)
  );

  // Pick the ack and read data of the slot owning the in-flight transaction.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = 16'h0000;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (id_q == e_n64_id'(i)) begin
        sel_ack   = dev_ack[i];
        sel_rdata = dev_rdata[16*i +: 16];
      end
    end
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    dwrite_d  = dwrite_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    ack_d     = 1'b0;
    hit_d     = 1'b0;
    tmo_d     = 1'b0;
    dreq_d    = '0;
    tmo_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && !busy_q) begin
          dwrite_d = req_write;
          daddr_d  = req_address;
          dwdata_d = req_wdata;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_hit) begin
          dreq_d  = NUM_DEVICES'(1) << dec_id;
          id_d    = dec_id;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          ack_d   = 1'b1;
          rdata_d = 16'h0000;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (sel_ack) begin
          ack_d   = 1'b1;
          hit_d   = 1'b1;
          rdata_d = sel_rdata;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ack_d   = 1'b1;
          hit_d   = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = 16'h0000;
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || ack_d;

    // Sticky error flags: a set in the same cycle as err_clear wins.
    err_tmo_d = tmo_set ? 1'b1 : (err_clear ? 1'b0 : err_tmo_q);
    err_ovr_d = (req && busy_q) ? 1'b1 : (err_clear ? 1'b0 : err_ovr_q);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      id_q      <= ID_SDRAM;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 16'h0000;
      hit_q     <= 1'b0;
      tmo_q     <= 1'b0;
      dreq_q    <= '0;
      dwrite_q  <= 1'b0;
      daddr_q   <= 32'h0000_0000;
      dwdata_q  <= 16'h0000;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      tmo_q     <= tmo_d;
      dreq_q    <= dreq_d;
      dwrite_q  <= dwrite_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign req_busy    = busy_q;
  assign req_ack     = ack_q;
  assign req_rdata   = rdata_q;
  assign req_hit     = hit_q;
  assign req_timeout = tmo_q;
  assign dev_request = dreq_q;
  assign dev_write   = dwrite_q;
  assign dev_address = daddr_q;
  assign dev_wdata   = dwdata_q;
  assign err_timeout = err_tmo_q;
  assign err_overrun = err_ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_n64_bus_scheduler.sv
// Bench for n64_bus_scheduler: directed vector table, hand-written corner
// sequences and randomized transactions against an address-map model.
module tb_n64_bus_scheduler;

  localparam int ND = 5;
  localparam int T  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_bootloader_en, cfg_flashram_en, cfg_dd_en;
  logic            req, req_write;
  logic [31:0]     req_address;
  logic [15:0]     req_wdata;
  logic            req_busy, req_ack, req_hit, req_timeout;
  logic [15:0]     req_rdata;
  logic [ND-1:0]   dev_request, dev_ack;
  logic            dev_write;
  logic [31:0]     dev_address;
  logic [15:0]     dev_wdata;
  logic [16*ND-1:0] dev_rdata;
  logic            err_timeout, err_overrun, err_clear;
  logic [1:0]      dbg_state;

  int checks   = 0;
  int failures = 0;

  n64_bus_scheduler #(.NUM_DEVICES(ND), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cfg_bootloader_en(cfg_bootloader_en), .cfg_flashram_en(cfg_flashram_en),
    .cfg_dd_en(cfg_dd_en),
    .req(req), .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
    .req_busy(req_busy), .req_ack(req_ack), .req_rdata(req_rdata),
    .req_hit(req_hit), .req_timeout(req_timeout),
    .dev_request(dev_request), .dev_write(dev_write), .dev_address(dev_address),
    .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clear(err_clear),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Address map model: ordered regions, first match wins.
  // en_sel: 0 = always this id, 1 = boot enable, 2 = flash enable, 3 = dd enable.
  // fb: id used when the region's enable is low, -1 = miss.
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          id;
    int          en_sel;
    int          fb;
  } region_t;

  region_t regions[4];

  task automatic ref_decode(input logic [31:0] a, input logic [2:0] en,
                            output logic h, output int id);
    h  = 1'b0;
    id = 0;
    for (int r = 0; r < 4; r++) begin
      if (a >= regions[r].lo && a <= regions[r].hi) begin
        if (regions[r].en_sel == 0 || en[regions[r].en_sel-1]) begin
          h = 1'b1; id = regions[r].id;
        end else if (regions[r].fb >= 0) begin
          h = 1'b1; id = regions[r].fb;
        end
        return;
      end
    end
  endtask

  // Driver + device responder + scoreboard for one transaction.
  // dly = cycles from dev_request to dev_ack (0 = device never acks).
  // noise = drive acks on a neighbouring slot while waiting.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [15:0] wd,
                         input logic [2:0] en, input int dly, input logic [15:0] rd,
                         input logic eh, input int eid, input logic noise);
    logic [15:0] exp_q[$];
    logic [ND-1:0] exp_req;
    int exp_cyc;
    logic done;
    exp_cyc = !eh ? 2 : (dly > 0 ? 3 + dly : 2 + T);
    exp_q.push_back((eh && dly > 0) ? rd : 16'h0000);
    done = 1'b0;
    @(negedge clk);
    cfg_bootloader_en = en[0];
    cfg_flashram_en   = en[1];
    cfg_dd_en         = en[2];
    req = 1'b1; req_write = w; req_address = a; req_wdata = wd;
    for (int cyc = 1; cyc < exp_cyc + 6; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      req_address = $urandom; req_wdata = 16'($urandom); req_write = 1'($urandom);
      exp_req = (eh && cyc == 2) ? ND'(1) << eid : '0;
      chk("dev_request", 64'(dev_request), 64'(exp_req));
      if (req_ack) begin
        chk("ack_cycle", 64'(cyc), 64'(exp_cyc));
        if (!(eh && dly == 0)) chk("req_hit", 64'(req_hit), 64'(eh));
        chk("req_timeout", 64'(req_timeout), 64'(eh && dly == 0));
        chk("req_rdata", 64'(req_rdata), 64'(exp_q.pop_front()));
        chk("dev_address", 64'(dev_address), 64'(a));
        chk("dev_write", 64'(dev_write), 64'(w));
        chk("dev_wdata", 64'(dev_wdata), 64'(wd));
        done = 1'b1;
        dev_ack = '0;
        break;
      end
      dev_ack   = '0;
      dev_rdata = {$urandom, $urandom, 16'($urandom)};
      if (eh && noise && cyc >= 2 && (dly == 0 || cyc < 2 + dly))
        dev_ack[(eid + 1) % ND] = 1'b1;
      if (eh && dly > 0 && cyc == 2 + dly) begin
        dev_ack[eid] = 1'b1;
        dev_rdata[16*eid +: 16] = rd;
      end
    end
    if (!done) chk("ack_seen", 64'(0), 64'(1));
    @(negedge clk);
    chk("busy_after", 64'(req_busy), 64'(0));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic [15:0] wd;
    logic [2:0]  en;   // {dd, flash, boot}
    int          dly;
    logic [15:0] rd;
    logic        exp_hit;
    int          exp_id;
  } vec_t;

  vec_t vecs[13];

  initial begin
    regions[0] = '{32'h1FFC_0000, 32'h1FFC_FFFF, 4, 0, -1};
    regions[1] = '{32'h1000_0000, 32'h1FFB_FFFF, 1, 1, 0};
    regions[2] = '{32'h0800_0000, 32'h0FFF_FFFF, 2, 2, 0};
    regions[3] = '{32'h0500_0000, 32'h05FF_FFFF, 3, 3, -1};

    vecs[0]  = '{32'h1000_0000, 1'b0, 16'h0000, 3'b000, 1, 16'hBEEF, 1'b1, 0};
    vecs[1]  = '{32'h1000_0000, 1'b0, 16'h0000, 3'b001, 2, 16'h1234, 1'b1, 1};
    vecs[2]  = '{32'h0500_0000, 1'b0, 16'h0000, 3'b000, 1, 16'h5555, 1'b0, 0};
    vecs[3]  = '{32'h0500_0000, 1'b0, 16'h0000, 3'b100, 1, 16'h0D0D, 1'b1, 3};
    vecs[4]  = '{32'h1FFC_0000, 1'b1, 16'hA5A5, 3'b111, 3, 16'hC0DE, 1'b1, 4};
    vecs[5]  = '{32'h1FFC_FFFF, 1'b0, 16'h0000, 3'b000, 1, 16'h00FF, 1'b1, 4};
    vecs[6]  = '{32'h1FFB_FFFF, 1'b0, 16'h0000, 3'b001, 1, 16'h7777, 1'b1, 1};
    vecs[7]  = '{32'h1FFD_0000, 1'b0, 16'h0000, 3'b111, 1, 16'h1111, 1'b0, 0};
    vecs[8]  = '{32'h0800_0000, 1'b1, 16'h4321, 3'b010, 4, 16'h8888, 1'b1, 2};
    vecs[9]  = '{32'h0FFF_FFFF, 1'b0, 16'h0000, 3'b000, 1, 16'h9999, 1'b1, 0};
    vecs[10] = '{32'h07FF_FFFF, 1'b0, 16'h0000, 3'b111, 1, 16'h2222, 1'b0, 0};
    vecs[11] = '{32'h05FF_FFFF, 1'b1, 16'hFACE, 3'b100, 2, 16'h3333, 1'b1, 3};
    vecs[12] = '{32'h0600_0000, 1'b0, 16'h0000, 3'b100, 1, 16'h4444, 1'b0, 0};

    reset = 1'b1;
    cfg_bootloader_en = 0; cfg_flashram_en = 0; cfg_dd_en = 0;
    req = 0; req_write = 0; req_address = '0; req_wdata = '0;
    dev_ack = '0; dev_rdata = '0; err_clear = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(req_busy), 64'(0));
    chk("rst_ack", 64'(req_ack), 64'(0));
    chk("rst_dev_request", 64'(dev_request), 64'(0));
    chk("rst_rdata", 64'(req_rdata), 64'(0));
    chk("rst_dev_address", 64'(dev_address), 64'(0));
    chk("rst_errs", 64'({err_timeout, err_overrun}), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 13; i++)
      run_txn(vecs[i].addr, vecs[i].w, vecs[i].wd, vecs[i].en, vecs[i].dly,
              vecs[i].rd, vecs[i].exp_hit, vecs[i].exp_id, 1'b0);

    // Ack on a non-selected slot must be ignored.
    run_txn(32'h1000_0000, 1'b0, 16'h0, 3'b000, 5, 16'h6A6A, 1'b1, 0, 1'b1);

    // Timeout: device never acks, neighbouring slot chatters.
    chk("err_timeout_pre", 64'(err_timeout), 64'(0));
    run_txn(32'h0800_0000, 1'b0, 16'h0, 3'b010, 0, 16'h0, 1'b1, 2, 1'b1);
    chk("err_timeout_set", 64'(err_timeout), 64'(1));
    repeat (3) @(negedge clk);
    chk("err_timeout_sticky", 64'(err_timeout), 64'(1));
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("err_timeout_clr", 64'(err_timeout), 64'(0));

    // Overrun: req while busy, then req during ack with err_clear.
    @(negedge clk);
    cfg_dd_en = 0;
    req = 1'b1; req_address = 32'h0000_0000; req_write = 0;
    @(negedge clk);
    chk("ovr_busy", 64'(req_busy), 64'(1));
    req_address = 32'h1000_0000;
    @(negedge clk);
    chk("ovr_ack", 64'(req_ack), 64'(1));
    chk("ovr_hit", 64'(req_hit), 64'(0));
    chk("ovr_flag", 64'(err_overrun), 64'(1));
    err_clear = 1'b1;
    @(negedge clk);
    chk("ovr_set_wins", 64'(err_overrun), 64'(1));
    chk("ovr_dropped_busy", 64'(req_busy), 64'(0));
    chk("ovr_dropped_addr", 64'(dev_address), 64'(0));
    req = 1'b0;
    @(negedge clk);
    err_clear = 1'b0;
    chk("ovr_clr", 64'(err_overrun), 64'(0));
    chk("ovr_idle", 64'(dbg_state), 64'(0));

    // Reset during WAIT.
    @(negedge clk);
    cfg_bootloader_en = 0;
    req = 1'b1; req_address = 32'h1000_0000;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rw_dev_request", 64'(dev_request), 64'(1));
    chk("rw_overrun", 64'(err_overrun), 64'(1));
    #1 reset = 1'b1;
    #1;
    chk("rw_dev_request_async", 64'(dev_request), 64'(0));
    chk("rw_busy", 64'(req_busy), 64'(0));
    chk("rw_flags", 64'({err_overrun, err_timeout}), 64'(0));
    chk("rw_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    dev_ack = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rw_no_ack", 64'({req_ack, req_busy}), 64'(0));
    end
    dev_ack = '0;
    run_txn(32'h1000_0000, 1'b0, 16'h0, 3'b000, 1, 16'hBEEF, 1'b1, 0, 1'b0);

    // Randomized transactions against the address-map model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [2:0]  en;
      logic        h;
      int          id;
      int          r;
      r = $urandom_range(0, 5);
      if (r < 4) a = regions[r].lo + ($urandom % (regions[r].hi - regions[r].lo + 1));
      else if (r == 4) a = $urandom;
      else a = 32'h2000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
      en = 3'($urandom);
      ref_decode(a, en, h, id);
      run_txn(a, 1'($urandom), 16'($urandom), en, $urandom_range(1, 6),
              16'($urandom), h, id, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
